// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by serial_adder.
module adder_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic w_c;

  always_comb begin
    w_c = ci;
    s   = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (x[i] & y[i]) | (x[i] & w_c) | (y[i] & w_c);
    end
  end

  assign co = w_c;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock with a registered carry, valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT == 0) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  assign w_accept  = in_valid & r_in_ready;
  assign w_release = r_out_valid & out_ready;
  assign w_last    = (r_cnt == CW'(NDIG - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1: invert B on load and force the initial carry.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x (r_a[DIGIT-1:0]),
    .y (r_b[DIGIT-1:0]),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Sum fills from the MSB end so the first (least significant) digit ends at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if ((r_state == IDLE) && w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= WIDTH'({w_s, r_sum} >> DIGIT);
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed tests on an 8/2 instance plus random sweeps on 8/1, 8/8, 16/4.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       rst_sw;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // Present operands, wait for acceptance, then count edges until out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, output int lat);
    int t;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_ready", 64'(in_ready), 64'(1));
  endtask

  // Random sweeps over other geometries, each with its own reset.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned GW = (g == 2) ? 16 : 8;
    localparam int unsigned GD = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

    logic          s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout;
    logic [GW-1:0] s_a, s_b, s_sum;
    logic [GW:0]   exp_v;
    logic          done;
`ifdef SERIAL_ADDER_SUB_EN
    logic          s_sub;
`endif

    serial_adder #(.WIDTH(GW), .DIGIT(GD)) u_sw (
      .clk      (clk),
      .rst      (rst_sw),
      .in_valid (s_in_valid),
      .in_ready (s_in_ready),
      .a        (s_a),
      .b        (s_b),
      .cin      (s_cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub      (s_sub),
`endif
      .out_valid(s_out_valid),
      .out_ready(s_out_ready),
      .sum      (s_sum),
      .cout     (s_cout)
    );

    initial begin
      done = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_a = '0; s_b = '0; s_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s_sub = 1'b0;
`endif
      wait (rst_sw === 1'b0);
      for (int op = 0; op < 1000; op++) begin
        int  t;
        bit  got;
        @(negedge clk);
        s_out_ready = 1'b0;
        s_a = GW'($urandom); s_b = GW'($urandom); s_cin = 1'($urandom);
        exp_v = (GW+1)'(s_a) + (GW+1)'(s_b) + (GW+1)'(s_cin);
`ifdef SERIAL_ADDER_SUB_EN
        s_sub = 1'($urandom);
        if (s_sub) exp_v = (GW+1)'(s_a) + (GW+1)'(GW'(~s_b)) + (GW+1)'(1);
`endif
        s_in_valid = 1'b1;
        t = 0;
        while (!s_in_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (!s_in_ready) check("sweep_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        s_a = GW'($urandom); s_b = GW'($urandom); s_cin = 1'($urandom);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
          if (k > 0) @(negedge clk);
          s_out_ready = 1'($urandom_range(0, 1));
          if (s_out_valid && s_out_ready) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) check("sweep_result_timeout", 64'(0), 64'(1));
        check("sweep_result", 64'({s_cout, s_sum}), 64'(exp_v));
        @(posedge clk);
      end
      @(negedge clk);
      s_out_ready = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         n_acc;
    int         last_acc;
    bit         need_new;
    logic [8:0] q[$];
    logic [8:0] e;

    rst = 1'b1; rst_sw = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    rst = 1'b0; rst_sw = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // FF + 01: wraps, carry out set, latency of NDIG edges
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("lat_ff01", 64'(lat), 64'(4));
    check("res_ff01", 64'({cout, sum}), 64'(ref_add8(8'hFF, 8'h01, 1'b0)));
    check("const_ff01", 64'({cout, sum}), 64'(9'h100));
    release_out();

    // 5A + 3C + 1 with backpressure hold
    run_op(8'h5A, 8'h3C, 1'b1, lat);
    check("res_5a3c", 64'({cout, sum}), 64'(9'h097));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'({cout, sum}), 64'(ref_add8(8'h5A, 8'h3C, 1'b1)));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    release_out();

    // Reset during the second BUSY cycle discards the operation at once
    @(negedge clk);
    a = 8'h77; b = 8'h99; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, lat);
    check("after_rst_lat", 64'(lat), 64'(4));
    check("after_rst_res", 64'({cout, sum}), 64'(9'h002));
    release_out();

    // Back-to-back with in_valid held high and out_ready tied high
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; last_acc = -1; need_new = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      if (need_new) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        need_new = 1'b0;
      end
      if (n_acc == 6) in_valid = 1'b0;
      check("no_overlap", 64'(in_ready & out_valid), 64'(0));
      if (out_valid) begin
        if (q.size() == 0) check("b2b_spurious", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          check("b2b_res", 64'({cout, sum}), 64'(e));
        end
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) check("b2b_period", 64'(c - last_acc), 64'(6));
        last_acc = c;
        n_acc++;
        q.push_back(ref_add8(a, b, cin));
        need_new = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'(6));
    check("b2b_drained", 64'(q.size()), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, lat);
    check("sub_1020", 64'({cout, sum}), 64'(9'h0F0));
    release_out();
    run_op(8'h20, 8'h10, 1'b0, lat);
    check("sub_2010", 64'({cout, sum}), 64'(9'h110));
    release_out();
    sub = 1'b0;
`endif

    wait (g_sw[0].done && g_sw[1].done && g_sw[2].done);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
